// File: rtl/controller_sysinfo_pkg.sv
// ---------------------------------------------------------------------------
// controller_sysinfo_pkg
//   Shared constants for the controller system-information slave:
//   register word offsets, STATUS bit positions, CAPS field layout and the
//   upper bound on user status words. Also a helper that assembles CAPS.
// ---------------------------------------------------------------------------
package controller_sysinfo_pkg;

    // Register word offsets
    localparam logic [3:0] OFS_ID        = 4'd0;
    localparam logic [3:0] OFS_TIMESTAMP = 4'd1;
    localparam logic [3:0] OFS_CAPS      = 4'd2;
    localparam logic [3:0] OFS_SCRATCH   = 4'd3;
    localparam logic [3:0] OFS_UPTIME_LO = 4'd4;
    localparam logic [3:0] OFS_UPTIME_HI = 4'd5;
    localparam logic [3:0] OFS_STATUS    = 4'd6;
    localparam logic [3:0] OFS_RSVD7     = 4'd7;
    localparam logic [3:0] OFS_USER0     = 4'd8;

    // STATUS bit indices (both sticky, write-1-to-clear)
    localparam int STATUS_WRAP  = 0;  // uptime counter wrapped to zero
    localparam int STATUS_ROWR  = 1;  // write hit a read-only/reserved offset
    localparam int STATUS_W     = 2;

    // CAPS field positions
    localparam int CAPS_NUM_USER_LSB = 0;
    localparam int CAPS_NUM_USER_W   = 8;
    localparam int CAPS_UPTIME_BIT   = 8;

    localparam int MAX_USER = 8;

    // Build the capability word from the configured user count and whether
    // the uptime counter is present.
    function automatic logic [31:0] caps_word(input int num_user, input logic uptime_en);
        logic [31:0] w;
        w = '0;
        w[CAPS_NUM_USER_LSB +: CAPS_NUM_USER_W] = num_user[CAPS_NUM_USER_W-1:0];
        w[CAPS_UPTIME_BIT] = uptime_en;
        return w;
    endfunction

endpackage

// File: rtl/controller_sysinfo_uptime.sv
// ---------------------------------------------------------------------------
// controller_sysinfo_uptime
//   64-bit free-running uptime counter with an atomic high-word snapshot.
//   When the low word is read, the high word of the same (pre-increment)
//   count is latched into a shadow so a following high-word read is
//   consistent even if a carry happened in between.
//
// Ports
//   i_clock      system clock, rising edge
//   i_reset      synchronous active-high reset
//   i_snap       low word is being read this cycle: latch high word
//   o_count_lo   current counter bits [31:0]
//   o_shadow_hi  latched high word (0 after reset)
//   o_wrap       high while the counter is all ones, i.e. it wraps to zero
//                at the end of this cycle
// ---------------------------------------------------------------------------
module controller_sysinfo_uptime (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_snap,
    output logic [31:0] o_count_lo,
    output logic [31:0] o_shadow_hi,
    output logic        o_wrap
);

    logic [63:0] r_count;
    logic [31:0] r_shadow;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count  <= '0;
            r_shadow <= '0;
        end else begin
            r_count <= r_count + 64'd1;
            if (i_snap) begin
                r_shadow <= r_count[63:32];
            end
        end
    end

    assign o_count_lo  = r_count[31:0];
    assign o_shadow_hi = r_shadow;
    assign o_wrap      = &r_count;

endmodule

// File: rtl/controller_sysinfo.sv
// ---------------------------------------------------------------------------
// controller_sysinfo
//   Avalon-MM system-information slave, fixed one-cycle read latency, never
//   stalls. Register map (word offsets):
//     0 ID (RO), 1 TIMESTAMP (RO), 2 CAPS (RO), 3 SCRATCH (RW, byte lanes),
//     4 UPTIME_LO (RO, snapshots high word), 5 UPTIME_HI (RO, snapshot),
//     6 STATUS (W1C), 7 reserved, 8.. USER[k] (RO), rest reserved (read 0).
//
// Handshake: a read is accepted in any cycle where read=1 and write=0;
// readdata/readdatavalid appear on the following cycle. If read and write
// are both high the write is performed and the read is dropped. readdata
// holds its last value while readdatavalid is low.
//
// Build option: define SYSINFO_UPTIME_EN to include the uptime counter,
// its snapshot shadow and STATUS[0]. Without it UPTIME_LO/HI read 0,
// STATUS[0] stays 0 and CAPS[8]=0.
//
// Ports
//   clock          system clock, rising edge
//   reset          synchronous active-high reset
//   address        word offset
//   read, write    one-cycle transfer strobes
//   writedata      write data
//   byteenable     write byte lanes (SCRATCH lanes, STATUS uses lane 0)
//   user_status    NUM_USER words, word k on bits [32k+31:32k]
//   readdata       registered read data
//   readdatavalid  high one cycle after an accepted read
// ---------------------------------------------------------------------------
module controller_sysinfo
    import controller_sysinfo_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID    = 32'h0000C001,
    parameter logic [31:0] TIMESTAMP    = 32'd1531293970,
    parameter int          NUM_USER     = 4,   // legal 0..8
    parameter logic [31:0] SCRATCH_INIT = 32'h0
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic [3:0]                                   address,
    input  logic                                         read,
    input  logic                                         write,
    input  logic [31:0]                                  writedata,
    input  logic [3:0]                                   byteenable,
    input  logic [32*((NUM_USER > 0) ? NUM_USER : 1)-1:0] user_status,
    output logic [31:0]                                  readdata,
    output logic                                         readdatavalid
);

`ifdef SYSINFO_UPTIME_EN
    localparam logic UPTIME_PRESENT = 1'b1;
`else
    localparam logic UPTIME_PRESENT = 1'b0;
`endif

    localparam logic [31:0] CAPS_VALUE = caps_word(NUM_USER, UPTIME_PRESENT);

    logic              w_rd_acc;
    logic              w_ro_wr;
    logic              w_status_clr;
    logic [31:0]       w_up_lo;
    logic [31:0]       w_up_hi;
    logic              w_wrap;
    logic [31:0]       w_rdata;
    logic [2:0]        w_user_idx;
    logic [31:0]       w_user [MAX_USER];
    logic [31:0]       w_scratch_nxt;
    logic [STATUS_W-1:0] w_status_nxt;

    logic [31:0]         r_scratch;
    logic [STATUS_W-1:0] r_status;

    // A simultaneous write wins over a read; the read is simply dropped.
    assign w_rd_acc = read & ~write;

    // Only SCRATCH and STATUS are writable; anything else is flagged.
    assign w_ro_wr = write && (address != OFS_SCRATCH) && (address != OFS_STATUS);

    assign w_status_clr = write && (address == OFS_STATUS) && byteenable[0];

    // Zero-pad the user words up to MAX_USER so the read mux can index any
    // USER offset without range checks.
    for (genvar k = 0; k < MAX_USER; k++) begin : g_user
        if (k < NUM_USER) begin : g_used
            assign w_user[k] = user_status[32*k +: 32];
        end else begin : g_zero
            assign w_user[k] = 32'h0;
        end
    end

    assign w_user_idx = 3'(address - OFS_USER0);

`ifdef SYSINFO_UPTIME_EN
    logic w_snap;
    assign w_snap = w_rd_acc && (address == OFS_UPTIME_LO);

    controller_sysinfo_uptime u_uptime (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_snap     (w_snap),
        .o_count_lo (w_up_lo),
        .o_shadow_hi(w_up_hi),
        .o_wrap     (w_wrap)
    );
`else
    assign w_up_lo = 32'h0;
    assign w_up_hi = 32'h0;
    assign w_wrap  = 1'b0;
`endif

    // Read data mux
    always_comb begin
        w_rdata = 32'h0;
        case (address)
            OFS_ID:        w_rdata = SYSTEM_ID;
            OFS_TIMESTAMP: w_rdata = TIMESTAMP;
            OFS_CAPS:      w_rdata = CAPS_VALUE;
            OFS_SCRATCH:   w_rdata = r_scratch;
            OFS_UPTIME_LO: w_rdata = w_up_lo;
            OFS_UPTIME_HI: w_rdata = w_up_hi;
            OFS_STATUS:    w_rdata = {{(32-STATUS_W){1'b0}}, r_status};
            OFS_RSVD7:     w_rdata = 32'h0;
            default: begin
                if (address >= OFS_USER0) begin
                    w_rdata = w_user[w_user_idx];
                end
            end
        endcase
    end

    // SCRATCH byte-lane update
    always_comb begin
        w_scratch_nxt = r_scratch;
        if (write && (address == OFS_SCRATCH)) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    w_scratch_nxt[8*b +: 8] = writedata[8*b +: 8];
                end
            end
        end
    end

    // STATUS: clear first, then set, so a set in the same cycle wins.
    always_comb begin
        w_status_nxt = r_status;
        if (w_status_clr) begin
            w_status_nxt = w_status_nxt & ~writedata[STATUS_W-1:0];
        end
        if (w_wrap) begin
            w_status_nxt[STATUS_WRAP] = 1'b1;
        end
        if (w_ro_wr) begin
            w_status_nxt[STATUS_ROWR] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_scratch     <= SCRATCH_INIT;
            r_status      <= '0;
            readdata      <= 32'h0;
            readdatavalid <= 1'b0;
        end else begin
            r_scratch     <= w_scratch_nxt;
            r_status      <= w_status_nxt;
            readdatavalid <= w_rd_acc;
            if (w_rd_acc) begin
                readdata <= w_rdata;
            end
        end
    end

endmodule
